// File: rtl/pmem_line_responder.sv
// Line-granular backing memory for the cache pmem port: one pmem_resp pulse LATENCY cycles after a request.
// Dropping the request mid-flight aborts it; define PMEM_ERRCHK_EN to add the sticky protocol checker on pmem_error.
module pmem_line_responder #(
  parameter int unsigned LATENCY       = 4,
  parameter int unsigned LINE_IDX_BITS = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         pmem_error
);

  localparam int unsigned LINES    = 1 << LINE_IDX_BITS;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]               state;
  logic [3:0]               cnt;
  logic                     op_write;
  logic [LINE_IDX_BITS-1:0] idx_q;
  logic [127:0]             wdata_q;
  logic [127:0]             mem [LINES];

  logic                     req;
  logic                     accept;
  logic                     busy_held;
  logic                     busy_done;
  logic                     enter_resp;
  logic                     c_write;
  logic [LINE_IDX_BITS-1:0] a_idx;
  logic [LINE_IDX_BITS-1:0] c_idx;
  logic [127:0]             c_wdata;
  logic                     addr_unused;

  assign req       = pmem_read | pmem_write;
  assign a_idx     = pmem_address[LINE_IDX_BITS+3:4];
  assign accept    = (state == ST_IDLE) && req;
  assign busy_held = (state == ST_BUSY) && req;
  assign busy_done = busy_held && (cnt == 4'd1);

  // With LATENCY==1 the commit happens on the accepting edge, so use live inputs.
  assign enter_resp = (accept && (LATENCY == 1)) || busy_done;
  assign c_write    = accept ? pmem_write : op_write;
  assign c_idx      = accept ? a_idx      : idx_q;
  assign c_wdata    = accept ? pmem_wdata : wdata_q;

  assign pmem_resp   = (state == ST_RESP);
  assign addr_unused = ^{pmem_address[3:0], pmem_address[15:LINE_IDX_BITS+4]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      op_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_write <= pmem_write;
            idx_q    <= a_idx;
            wdata_q  <= pmem_wdata;
            cnt      <= CNT_INIT;
            state    <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!req) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Array is deliberately outside reset so lines survive a reset pulse.
  always_ff @(posedge clk) begin
    if (enter_resp && c_write) mem[c_idx] <= c_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pmem_rdata <= '0;
    end else if (enter_resp && !c_write) begin
      pmem_rdata <= mem[c_idx];
    end
  end

`ifdef PMEM_ERRCHK_EN
  logic [11:0] addr_hi_q;
  logic        err_q;
  logic        err_cond;

  assign err_cond = ((accept || busy_held) && pmem_read && pmem_write) ||
                    (busy_held && (pmem_address[15:4] != addr_hi_q)) ||
                    (busy_held && op_write && (pmem_wdata != wdata_q));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_hi_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) addr_hi_q <= pmem_address[15:4];
      if (err_cond) err_q <= 1'b1;
    end
  end

  assign pmem_error = err_q;
`else
  assign pmem_error = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench: one LATENCY=4 instance for the main protocol and one LATENCY=1 instance for the short path.
module tb_pmem_line_responder;

`ifdef PMEM_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  localparam logic [127:0] PAT_A = {8{16'h1111}};
  localparam logic [127:0] PAT_B = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] PAT_C = 128'hcafe_f00d_1357_9bdf_2468_ace0_0bad_beef;
  localparam logic [127:0] PAT_D = {4{32'hdead_beef}};
  localparam logic [127:0] PAT_E = {4{32'h5a5a_a5a5}};
  localparam logic [127:0] PAT_F = {4{32'h7777_0001}};
  localparam logic [127:0] PAT_G = {2{64'h0f0f_1234_5678_f0f0}};

  logic         clk;
  logic         reset_n;
  logic         rd0, wr0, rd1, wr1;
  logic [15:0]  addr0, addr1;
  logic [127:0] wdata0, wdata1, rdata0, rdata1;
  logic         resp0, resp1, error0, error1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_cnt = 0;

  pmem_line_responder #(.LATENCY(4), .LINE_IDX_BITS(6)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .pmem_read(rd0), .pmem_write(wr0), .pmem_address(addr0), .pmem_wdata(wdata0),
    .pmem_rdata(rdata0), .pmem_resp(resp0), .pmem_error(error0)
  );

  pmem_line_responder #(.LATENCY(1), .LINE_IDX_BITS(6)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1), .pmem_wdata(wdata1),
    .pmem_rdata(rdata1), .pmem_resp(resp1), .pmem_error(error1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Called just after a rising edge; that cycle is cycle 0 of the request.
  task automatic do_req(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [127:0] d, output int lat, output logic [127:0] rdat,
                        output int stamp);
    bit seen;
    seen  = 1'b0;
    lat   = 0;
    rdat  = '0;
    stamp = 0;
    if (sel) begin rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d; end
    else     begin rd0 = rd; wr0 = wr; addr0 = a; wdata0 = d; end
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (sel ? resp1 : resp0) begin
        seen  = 1'b1;
        rdat  = sel ? rdata1 : rdata0;
        stamp = cyc_cnt;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    @(posedge clk); #1;
    if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
    else     begin rd0 = 1'b0; wr0 = 1'b0; end
  endtask

  initial begin
    int lat, st1, st2, hits;
    logic [127:0] rd_v;

    rd0 = 0; wr0 = 0; addr0 = '0; wdata0 = '0;
    rd1 = 0; wr1 = 0; addr1 = '0; wdata1 = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("reset_resp", 128'(resp0), 128'd0);
    chk("reset_rdata", rdata0, 128'd0);
    chk("reset_error", 128'(error0), 128'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    do_req(0, 0, 1, 16'h0120, PAT_A, lat, rd_v, st1);
    chk("wr_a_latency", 128'(lat), 128'd4);
    do_req(0, 1, 0, 16'h012F, '0, lat, rd_v, st1);
    chk("rd_a_latency", 128'(lat), 128'd4);
    chk("rd_a_data", rd_v, PAT_A);

    do_req(0, 0, 1, 16'h0000, PAT_B, lat, rd_v, st1);
    chk("wr_b_latency", 128'(lat), 128'd4);
    do_req(0, 0, 1, 16'h0010, PAT_C, lat, rd_v, st1);
    do_req(0, 1, 0, 16'h0000, '0, lat, rd_v, st1);
    chk("b2b_rd_b_data", rd_v, PAT_B);
    do_req(0, 1, 0, 16'h0010, '0, lat, rd_v, st2);
    chk("b2b_rd_c_data", rd_v, PAT_C);
    chk("b2b_spacing", 128'(st2 - st1), 128'd5);
    @(negedge clk);
    chk("resp_one_cycle", 128'(resp0), 128'd0);
    @(posedge clk); #1;

    do_req(0, 0, 1, 16'h0400, PAT_D, lat, rd_v, st1);
    chk("rdata_hold_over_write", rdata0, PAT_C);
    do_req(0, 1, 0, 16'h0000, '0, lat, rd_v, st1);
    chk("alias_rd_data", rd_v, PAT_D);

    do_req(0, 1, 1, 16'h0030, PAT_E, lat, rd_v, st1);
    chk("rdwr_latency", 128'(lat), 128'd4);
    chk("rdwr_error", 128'(error0), 128'(ERRCHK));
    do_req(0, 1, 0, 16'h0030, '0, lat, rd_v, st1);
    chk("rdwr_is_write", rd_v, PAT_E);

    // Write dropped in cycle 2 must not commit nor respond.
    hits = 0;
    wr0 = 1'b1; addr0 = 16'h0120; wdata0 = PAT_F;
    @(negedge clk); hits += int'(resp0); @(posedge clk); #1;
    @(negedge clk); hits += int'(resp0); @(posedge clk); #1;
    wr0 = 1'b0;
    @(negedge clk); hits += int'(resp0); @(posedge clk); #1;
    chk("drop_no_resp", 128'(hits), 128'd0);
    do_req(0, 1, 0, 16'h0120, '0, lat, rd_v, st1);
    chk("drop_idle_latency", 128'(lat), 128'd4);
    chk("drop_no_commit", rd_v, PAT_A);

    rd0 = 1'b1; addr0 = 16'h0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("midbusy_reset_resp", 128'(resp0), 128'd0);
    chk("midbusy_reset_rdata", rdata0, 128'd0);
    chk("midbusy_reset_error", 128'(error0), 128'd0);
    rd0 = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    do_req(0, 1, 0, 16'h0010, '0, lat, rd_v, st1);
    chk("array_kept_over_reset", rd_v, PAT_C);

    do_req(1, 0, 1, 16'h0050, PAT_G, lat, rd_v, st1);
    chk("lat1_wr_latency", 128'(lat), 128'd1);
    do_req(1, 1, 0, 16'h0050, '0, lat, rd_v, st1);
    chk("lat1_rd_latency", 128'(lat), 128'd1);
    chk("lat1_rd_data", rd_v, PAT_G);
    @(negedge clk);
    chk("lat1_resp_one_cycle", 128'(resp1), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
